// File: rtl/display7_scroll_scan.sv
`default_nettype none
// ============================================================================
//  Module   : display7_scroll_scan
//  Purpose  : Multiplexed 7-segment scan engine. Cycles through NUM_DIGITS
//             digits at a rate set by a clock-enable counter. It shows a
//             latched message in one of three modes: static, scrolling or
//             blinking. char_code goes to the display7_letter decoder.
//  Ports    :
//    clk        in   system clock
//    rst_n      in   asynchronous active-low reset
//    load       in   one-cycle strobe, latches msg_data / msg_len / mode
//    msg_data   in   MSG_LEN characters, char k at [k*CHAR_W +: CHAR_W]
//    msg_len    in   number of valid characters (clamped to MSG_LEN)
//    mode       in   00 static, 01 scroll, 10 blink, 11 static
//    char_code  out  character code for the currently enabled digit
//    bit_ctrl   out  active-low one-cold digit enables
//    frame_done out  one-cycle pulse on the tick that completes a frame
//  Revision : 1.0  initial release
// ============================================================================
module display7_scroll_scan #(
    parameter int NUM_DIGITS    = 8,
    parameter int CHAR_W        = 5,
    parameter int MSG_LEN       = 16,
    parameter int SCAN_DIV      = 100000,
    parameter int SCROLL_FRAMES = 64,
    parameter int BLINK_FRAMES  = 128
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic [MSG_LEN*CHAR_W-1:0]      msg_data,
    input  logic [$clog2(MSG_LEN+1)-1:0]   msg_len,
    input  logic [1:0]                     mode,
    output logic [CHAR_W-1:0]              char_code,
    output logic [NUM_DIGITS-1:0]          bit_ctrl,
    output logic                           frame_done
);

    localparam int c_LEN_W = $clog2(MSG_LEN + 1);
    localparam int c_CNT_W = $clog2(SCAN_DIV);
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Wide enough for offset + digit index before the single wrap subtract.
    localparam int c_POS_W = $clog2(2 * (MSG_LEN + NUM_DIGITS));
    localparam int c_SF_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam int c_BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [1:0] c_MODE_STATIC = 2'b00;
    localparam logic [1:0] c_MODE_SCROLL = 2'b01;
    localparam logic [1:0] c_MODE_BLINK  = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0]          r_scan_cnt;
    logic [c_IDX_W-1:0]          r_idx;        // digit shown on the next tick
    logic [c_POS_W-1:0]          r_ofs;
    logic [c_SF_W-1:0]           r_scroll_cnt;
    logic [c_BF_W-1:0]           r_blink_cnt;
    logic                        r_blink_on;
    logic [c_LEN_W-1:0]          r_len;
    logic [1:0]                  r_mode;
    logic [MSG_LEN*CHAR_W-1:0]   r_data;
    logic [CHAR_W-1:0]           r_char;
    logic [NUM_DIGITS-1:0]       r_bit_ctrl;
    logic                        r_frame_done;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                        w_tick;
    logic                        w_wrap;
    logic [c_LEN_W-1:0]          w_load_len;
    logic [c_LEN_W-1:0]          w_len;
    logic [1:0]                  w_mode;
    logic [MSG_LEN*CHAR_W-1:0]   w_data;
    logic [c_POS_W-1:0]          w_ofs;
    logic                        w_blink_on;
    logic [c_POS_W-1:0]          w_virt_len;
    logic [c_POS_W-1:0]          w_pos_raw;
    logic [c_POS_W-1:0]          w_pos;
    logic [c_POS_W-1:0]          w_sel;
    logic [CHAR_W-1:0]           w_char;
    logic                        w_show_off;
    logic [c_POS_W-1:0]          w_ofs_inc;
    logic [c_POS_W-1:0]          w_ofs_next;
    logic [NUM_DIGITS-1:0]       w_onehot;

    assign w_tick = (r_scan_cnt == c_CNT_W'(SCAN_DIV - 1));
    assign w_wrap = w_tick && (r_idx == c_IDX_W'(NUM_DIGITS - 1));

    assign w_load_len = (msg_len > c_LEN_W'(MSG_LEN)) ? c_LEN_W'(MSG_LEN) : msg_len;

    // A load coinciding with a tick must already be visible on that tick,
    // so the content path looks through the latch when load is high.
    assign w_len      = load ? w_load_len : r_len;
    assign w_mode     = load ? mode       : r_mode;
    assign w_data     = load ? msg_data   : r_data;
    assign w_ofs      = load ? '0         : r_ofs;
    assign w_blink_on = load ? 1'b1       : r_blink_on;

    // Virtual scroll string: len characters followed by NUM_DIGITS blanks.
    assign w_virt_len = c_POS_W'(w_len) + c_POS_W'(NUM_DIGITS);

    // offset < L and idx < NUM_DIGITS <= L, so one subtract completes the mod.
    assign w_pos_raw = w_ofs + c_POS_W'(r_idx);
    assign w_pos     = (w_pos_raw >= w_virt_len) ? (w_pos_raw - w_virt_len) : w_pos_raw;
    assign w_sel     = (w_mode == c_MODE_SCROLL) ? w_pos : c_POS_W'(r_idx);

    // Character fetch. Positions at or beyond len are blank (all ones).
    always_comb begin
        w_char = '1;
        for (int k = 0; k < MSG_LEN; k++) begin
            if ((w_sel == c_POS_W'(k)) && (w_sel < c_POS_W'(w_len))) begin
                w_char = w_data[k*CHAR_W +: CHAR_W];
            end
        end
    end

    assign w_show_off = (w_mode == c_MODE_BLINK) && !w_blink_on;

    assign w_ofs_inc  = r_ofs + 1'b1;
    assign w_ofs_next = (w_ofs_inc >= w_virt_len) ? '0 : w_ofs_inc;

    assign w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt   <= '0;
            r_idx        <= '0;
            r_ofs        <= '0;
            r_scroll_cnt <= '0;
            r_blink_cnt  <= '0;
            r_blink_on   <= 1'b1;
            r_len        <= '0;
            r_mode       <= c_MODE_STATIC;
            r_data       <= '1;
            r_char       <= '1;
            r_bit_ctrl   <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_scan_cnt   <= w_tick ? '0 : (r_scan_cnt + 1'b1);
            r_frame_done <= w_wrap;

            // Enable and character are updated together on the tick.
            if (w_tick) begin
                r_idx <= (r_idx == c_IDX_W'(NUM_DIGITS - 1)) ? '0 : (r_idx + 1'b1);
                if (w_show_off) begin
                    r_bit_ctrl <= '1;
                    r_char     <= '1;
                end else begin
                    r_bit_ctrl <= ~w_onehot;
                    r_char     <= w_char;
                end
            end

            // Load takes priority over a coincident frame wrap so that the
            // frame counters restart from zero.
            if (load) begin
                r_len        <= w_load_len;
                r_mode       <= mode;
                r_data       <= msg_data;
                r_ofs        <= '0;
                r_scroll_cnt <= '0;
                r_blink_cnt  <= '0;
                r_blink_on   <= 1'b1;
            end else if (w_wrap) begin
                if (r_scroll_cnt == c_SF_W'(SCROLL_FRAMES - 1)) begin
                    r_scroll_cnt <= '0;
                    // An empty message keeps the offset pinned at zero.
                    if ((r_mode == c_MODE_SCROLL) && (r_len != '0)) begin
                        r_ofs <= w_ofs_next;
                    end
                end else begin
                    r_scroll_cnt <= r_scroll_cnt + 1'b1;
                end

                if (r_blink_cnt == c_BF_W'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    assign char_code  = r_char;
    assign bit_ctrl   = r_bit_ctrl;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display7_scroll_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display7_scroll_scan
//  Purpose  : Directed self-checking bench for display7_scroll_scan with
//             NUM_DIGITS=4, SCAN_DIV=4, SCROLL_FRAMES=1, BLINK_FRAMES=2.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_display7_scroll_scan;

    localparam int c_ND = 4;
    localparam int c_CW = 5;
    localparam int c_ML = 16;
    localparam int c_SD = 4;
    localparam int c_SF = 1;
    localparam int c_BF = 2;
    localparam int c_LW = $clog2(c_ML + 1);
    localparam logic [c_CW-1:0] c_BL = '1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  load = 1'b0;
    logic [c_ML*c_CW-1:0]  msg_data = '0;
    logic [c_LW-1:0]       msg_len = '0;
    logic [1:0]            mode = 2'b00;
    logic [c_CW-1:0]       char_code;
    logic [c_ND-1:0]       bit_ctrl;
    logic                  frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    display7_scroll_scan #(
        .NUM_DIGITS    (c_ND),
        .CHAR_W        (c_CW),
        .MSG_LEN       (c_ML),
        .SCAN_DIV      (c_SD),
        .SCROLL_FRAMES (c_SF),
        .BLINK_FRAMES  (c_BF)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .msg_data   (msg_data),
        .msg_len    (msg_len),
        .mode       (mode),
        .char_code  (char_code),
        .bit_ctrl   (bit_ctrl),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [4*c_CW-1:0] pack4(input logic [c_CW-1:0] d0, input logic [c_CW-1:0] d1,
                                                input logic [c_CW-1:0] d2, input logic [c_CW-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // Bounded wait for a frame_done pulse; leaves us 1 ns after that edge.
    task automatic wait_fd(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // Starting 1 ns after a frame_done edge, check the following frame. A
    // pending load is dropped after the first edge.
    task automatic check_frame(input string tag, input logic [4*c_CW-1:0] exp_ch, input bit blanked);
        logic [c_ND-1:0] eb;
        for (int d = 0; d < c_ND; d++) begin
            if (d == 0) begin
                @(posedge clk);
                #1;
                load = 1'b0;
                step(3);
            end else begin
                step(4);
            end
            eb = blanked ? '1 : ~(c_ND'(1) << d);
            chk($sformatf("%s d%0d bit_ctrl", tag, d), 32'(bit_ctrl), 32'(eb));
            chk($sformatf("%s d%0d char", tag, d), 32'(char_code), 32'(exp_ch[d*c_CW +: c_CW]));
        end
        chk($sformatf("%s frame_done", tag), 32'(frame_done), 32'd1);
    endtask

    task automatic set_msg(input int len, input logic [1:0] md,
                           input logic [c_CW-1:0] c0, input logic [c_CW-1:0] c1,
                           input logic [c_CW-1:0] c2, input logic [c_CW-1:0] c3);
        msg_data = '1;
        msg_data[0*c_CW +: c_CW] = c0;
        msg_data[1*c_CW +: c_CW] = c1;
        msg_data[2*c_CW +: c_CW] = c2;
        msg_data[3*c_CW +: c_CW] = c3;
        msg_len  = c_LW'(len);
        mode     = md;
        load     = 1'b1;
    endtask

    logic [4*c_CW-1:0] scroll_tab [7];
    logic [c_CW-1:0]   vch [4];

    initial begin
        // Scroll of "5 6" over L=6: frame k shows V[k..k+3 mod 6].
        scroll_tab[0] = pack4(5, 6, c_BL, c_BL);
        scroll_tab[1] = pack4(6, c_BL, c_BL, c_BL);
        scroll_tab[2] = pack4(c_BL, c_BL, c_BL, c_BL);
        scroll_tab[3] = pack4(c_BL, c_BL, c_BL, 5);
        scroll_tab[4] = pack4(c_BL, c_BL, 5, 6);
        scroll_tab[5] = pack4(c_BL, 5, 6, c_BL);
        scroll_tab[6] = pack4(5, 6, c_BL, c_BL);

        // ---------------- reset state and raw scan ----------------
        #2 rst_n = 1'b0;
        #1;
        chk("reset bit_ctrl", 32'(bit_ctrl), 32'hF);
        chk("reset char", 32'(char_code), 32'd31);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk($sformatf("pre-tick%0d bit_ctrl", i), 32'(bit_ctrl), 32'hF);
            chk($sformatf("pre-tick%0d char", i), 32'(char_code), 32'd31);
        end
        step(1);
        chk("tick1 bit_ctrl", 32'(bit_ctrl), 32'hE);
        chk("tick1 char", 32'(char_code), 32'd31);
        chk("tick1 frame_done", 32'(frame_done), 32'd0);
        step(4);
        chk("tick2 bit_ctrl", 32'(bit_ctrl), 32'hD);
        step(4);
        chk("tick3 bit_ctrl", 32'(bit_ctrl), 32'hB);
        step(4);
        chk("tick4 bit_ctrl", 32'(bit_ctrl), 32'h7);
        chk("tick4 frame_done", 32'(frame_done), 32'd1);
        step(1);
        chk("frame_done width", 32'(frame_done), 32'd0);
        step(3);
        chk("tick5 bit_ctrl", 32'(bit_ctrl), 32'hE);

        // ---------------- static ----------------
        wait_fd("sync static");
        set_msg(3, 2'b00, 2, 7, 9, 4);
        check_frame("static", pack4(2, 7, 9, c_BL), 1'b0);

        // ---------------- scroll ----------------
        set_msg(2, 2'b01, 5, 6, 0, 0);
        for (int f = 0; f < 7; f++)
            check_frame($sformatf("scroll f%0d", f), scroll_tab[f], 1'b0);

        // ---------------- blink ----------------
        set_msg(4, 2'b10, 1, 3, 4, 8);
        check_frame("blink f0", pack4(1, 3, 4, 8), 1'b0);
        check_frame("blink f1", pack4(1, 3, 4, 8), 1'b0);
        check_frame("blink f2", pack4(c_BL, c_BL, c_BL, c_BL), 1'b1);
        check_frame("blink f3", pack4(c_BL, c_BL, c_BL, c_BL), 1'b1);
        check_frame("blink f4", pack4(1, 3, 4, 8), 1'b0);

        // ---------------- length clamp: 20 -> 16, L = 20 ----------------
        for (int k = 0; k < c_ML; k++) msg_data[k*c_CW +: c_CW] = c_CW'(k);
        msg_len = c_LW'(20);
        mode    = 2'b01;
        load    = 1'b1;
        for (int f = 0; f <= 20; f++) begin
            for (int d = 0; d < c_ND; d++) begin
                int j;
                j = (f + d) % 20;
                vch[d] = (j < c_ML) ? c_CW'(j) : c_BL;
            end
            check_frame($sformatf("clamp f%0d", f), pack4(vch[0], vch[1], vch[2], vch[3]), 1'b0);
        end

        // ---------------- asynchronous reset mid-scroll ----------------
        set_msg(2, 2'b01, 5, 6, 0, 0);
        for (int f = 0; f < 3; f++)
            check_frame($sformatf("prereset f%0d", f), scroll_tab[f], 1'b0);
        step(4);
        chk("ofs3 d0 bit_ctrl", 32'(bit_ctrl), 32'hE);
        #2 rst_n = 1'b0;
        #1;
        chk("async bit_ctrl", 32'(bit_ctrl), 32'hF);
        chk("async char", 32'(char_code), 32'd31);
        chk("async frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        chk("post-reset pre-tick bit_ctrl", 32'(bit_ctrl), 32'hF);
        step(1);
        chk("post-reset tick bit_ctrl", 32'(bit_ctrl), 32'hE);
        chk("post-reset tick char", 32'(char_code), 32'd31);
        wait_fd("sync post-reset");
        check_frame("post-reset", pack4(c_BL, c_BL, c_BL, c_BL), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display7_scroll_scan.md
Name: display7_scroll_scan

Overview:
Parametrised multiplexed 7-segment scan engine, the successor to the fixed 5-digit colour-name display.
- Drives NUM_DIGITS digits from a latched message of up to MSG_LEN character codes.
- Supports static, scrolling and blinking modes.
- Generates its scan timing from a clock-enable counter instead of a derived clock.
- char_code feeds the existing display7_letter decoder unchanged.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..8)
CHAR_W, 5, character code width; all-ones code = blank
MSG_LEN, 16, maximum message length in characters
SCAN_DIV, 100000, clk cycles per digit slot (>=2)
SCROLL_FRAMES, 64, full scan frames per scroll step
BLINK_FRAMES, 128, full scan frames per blink half-period

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
load  in  1  one-cycle strobe; latch msg_data, msg_len, mode
msg_data  in  MSG_LEN*CHAR_W  char k at bits [k*CHAR_W +: CHAR_W]; char 0 maps to digit 0 (rightmost)
msg_len  in  clog2(MSG_LEN+1)  valid characters in msg_data
mode  in  2  00 static, 01 scroll, 10 blink, 11 treated as static
char_code  out  CHAR_W  code for the currently enabled digit
bit_ctrl  out  NUM_DIGITS  active-low digit enables, one-cold
frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - bit_ctrl all ones; char_code all ones (blank); frame_done 0.
  - Scan counter 0, digit index 0, scroll offset 0, frame counters 0, blink phase ON.
  - Latched length 0, latched mode static.
- Scan tick:
  - The counter runs 0..SCAN_DIV-1; the tick is asserted on the cycle the count equals SCAN_DIV-1, and the count then returns to 0.
  - On each tick the digit index advances mod NUM_DIGITS.
  - bit_ctrl and char_code are registered on the same edge, so they are always aligned and never skewed by a cycle.
  - The first tick after reset shows digit 0; bit_ctrl = ~(1<<idx).
- frame_done: asserted for exactly one clk, on the tick where idx goes NUM_DIGITS-1 -> 0. Frame counters increment on frame_done.
- Load:
  - load=1 latches all three inputs on that edge.
  - msg_len > MSG_LEN is clamped to MSG_LEN.
  - Scroll offset, both frame counters and the blink phase (ON) are reset.
  - The scan counter and idx are NOT reset, so there is no glitch in scan rate.
  - The new content appears on the next tick. load on consecutive cycles: the last one wins.
- Static mode: digit i shows char i if i < len, else blank.
- Scroll mode:
  - Virtual string V = len chars followed by NUM_DIGITS blanks; L = len + NUM_DIGITS.
  - Digit i shows V[(offset+i) mod L].
  - Every SCROLL_FRAMES frames, offset = (offset+1) mod L, so text moves toward digit 0.
  - Mod is computed by compare-subtract; no divider is allowed.
  - len = 0 gives all blank and offset stays 0.
- Blink mode:
  - Content is as in static mode.
  - The phase toggles every BLINK_FRAMES frames.
  - Phase OFF forces bit_ctrl all ones and char_code blank while the scan and frame counters keep running.
- Mid-operation reset: all state returns to reset values immediately, asynchronously. Deassertion is clean; the first tick after deassertion occurs SCAN_DIV cycles later.
- Simultaneous load and tick: the tick uses the new latched data. If a frame_done pulse coincides with load, the frame counters are cleared rather than incremented.

Test Plan:
- Params NUM_DIGITS=4, SCAN_DIV=4, reset released, no load -> bit_ctrl 1111 and char_code 31 until the 4th clk; then bit_ctrl 1110, 1101, 1011, 0111, 1110 every 4 clk; frame_done pulses once per 16 clk.
- Static load, len=3, chars {2,7,9} -> digits 0..3 show 2, 7, 9, 31; digit 3 is blank.
- Scroll, len=2, chars {5,6}, SCROLL_FRAMES=1 (L=6) -> digit 0 shows 5, 6, 31, 31, 31, 31, 5 on successive frames, wrapping after 6 steps.
- Blink, BLINK_FRAMES=2 -> 2 frames normal scan, 2 frames bit_ctrl 1111 and char_code 31, repeating; frame_done keeps pulsing throughout.
- msg_len=20 with MSG_LEN=16 -> clamped; scroll wraps at L=20 (NUM_DIGITS=4).
- rst_n pulled low mid-scroll at offset 3 -> outputs reset in the same cycle (async); after release, static blank with offset 0.
